// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, status flag
// bit positions and FSM state encoding.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file for the ALU issue controller: two operand read ports, one
// debug read port, one write port, cleared by asynchronous reset.
// Optional macro ALU_ISSUE_ZERO_REG_EN makes r0 a hard-wired zero register.
module alu_issue_ctrl_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

`ifdef ALU_ISSUE_ZERO_REG_EN
  // r0 is constant zero: writes to it are dropped, reads return zero
  assign wr_ok   = we && (waddr != '0);
  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
`else
  assign wr_ok    = we;
  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];
`endif

  // Storage array: cleared on reset, single write port otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one decoded instruction at a time, drives
// registered operands to a combinational ALU, retires its result one cycle
// later into the register file and the sticky NZCV status register.
// Optional macro ALU_ISSUE_ZERO_REG_EN (see regfile) hard-wires r0 to zero.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1; instr_ready is 1 only in IDLE and never in reset.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHIFT_W = 5,
  parameter int REG_AW  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [3:0]         instr_op,
  input  logic [REG_AW-1:0]  instr_rd,
  input  logic [REG_AW-1:0]  instr_rs1,
  input  logic [REG_AW-1:0]  instr_rs2,
  input  logic [SHIFT_W-1:0] instr_shamt,
  output logic [3:0]         alu_optcode,
  output logic [DATA_W-1:0]  alu_r2,
  output logic [DATA_W-1:0]  alu_r3,
  output logic [SHIFT_W-1:0] alu_shift,
  input  logic [DATA_W-1:0]  alu_r1,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               alu_carry,
  input  logic               load_en,
  input  logic [REG_AW-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic [3:0]         status_nzcv,
  output logic               illegal_op,
  output logic               dbg_state
);

  state_t            state;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              handshake;
  logic              op_legal;
  logic              op_writes;
  logic              upd_c;
  logic              upd_v;

  assign dbg_state   = state;
  assign instr_ready = (state == ST_IDLE) && !reset;
  assign handshake   = instr_valid && instr_ready;

  // Opcode classification for the instruction currently in EXEC
  assign op_legal  = (alu_optcode <= OP_CMP);
  assign op_writes = (alu_optcode <= OP_ROR);
  assign upd_c = alu_optcode inside {OP_ADD, OP_SUB, OP_MUL, OP_SHR, OP_SHL, OP_ROR, OP_CMP};
  assign upd_v = alu_optcode inside {OP_ADD, OP_SUB, OP_MUL, OP_CMP};

  // Write port arbitration: host load in IDLE, retire in EXEC
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = load_addr;
    rf_wdata = load_data;
    if (state == ST_EXEC) begin
      rf_we    = op_writes;
      rf_waddr = rd_q;
      rf_wdata = alu_r1;
    end else begin
      rf_we = load_en;
    end
  end

  alu_issue_ctrl_regfile #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr_a  (instr_rs1),
    .rdata_a  (rf_a),
    .raddr_b  (instr_rs2),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Issue/retire FSM with registered ALU inputs, retire outputs and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_q        <= '0;
      alu_optcode <= '0;
      alu_r2      <= '0;
      alu_r3      <= '0;
      alu_shift   <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      status_nzcv <= '0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wb_valid   <= 1'b0;
          illegal_op <= 1'b0;
          if (handshake) begin
            alu_optcode <= instr_op;
            alu_r2      <= rf_a;
            alu_r3      <= rf_b;
            alu_shift   <= instr_shamt;
            rd_q        <= instr_rd;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wb_valid   <= op_legal;
          illegal_op <= !op_legal;
          if (op_legal) begin
            wb_rd   <= rd_q;
            wb_data <= alu_r1;
            status_nzcv[FLAG_N] <= alu_negative;
            status_nzcv[FLAG_Z] <= alu_zero;
            if (upd_c) status_nzcv[FLAG_C] <= alu_carry;
            if (upd_v) status_nzcv[FLAG_V] <= alu_overflow;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives the result inputs,
// a table of instructions with hand-computed results, plus multi-cycle
// sequences for concurrent load, back-to-back issue and mid-EXEC reset.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs1, instr_rs2;
  logic [4:0]  instr_shamt;
  logic [3:0]  alu_optcode;
  logic [31:0] alu_r2, alu_r3;
  logic [4:0]  alu_shift;
  logic [31:0] alu_r1;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [31:0] load_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  status_nzcv;
  logic        illegal_op;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_shamt(instr_shamt),
    .alu_optcode(alu_optcode), .alu_r2(alu_r2), .alu_r3(alu_r3),
    .alu_shift(alu_shift), .alu_r1(alu_r1),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .status_nzcv(status_nzcv), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  logic [63:0] prod;
  always_comb begin
    alu_r1       = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    prod         = {32'b0, alu_r2} * {32'b0, alu_r3};
    case (alu_optcode)
      4'd0: begin
        {alu_carry, alu_r1} = {1'b0, alu_r2} + {1'b0, alu_r3};
        alu_overflow = (alu_r2[31] == alu_r3[31]) && (alu_r1[31] != alu_r2[31]);
      end
      4'd1, 4'd9: begin
        alu_r1       = alu_r2 - alu_r3;
        alu_carry    = alu_r2 < alu_r3;
        alu_overflow = (alu_r2[31] != alu_r3[31]) && (alu_r1[31] != alu_r2[31]);
      end
      4'd2: begin
        alu_r1       = prod[31:0];
        alu_carry    = |prod[63:32];
        alu_overflow = |prod[63:32];
      end
      4'd3: alu_r1 = alu_r2 | alu_r3;
      4'd4: alu_r1 = alu_r2 & alu_r3;
      4'd5: alu_r1 = alu_r2 ^ alu_r3;
      4'd6: begin
        alu_r1    = alu_r2 >> alu_shift;
        alu_carry = (alu_shift != 0) ? alu_r2[int'(alu_shift) - 1] : 1'b0;
      end
      4'd7: begin
        alu_r1    = alu_r2 << alu_shift;
        alu_carry = (alu_shift != 0) ? alu_r2[32 - int'(alu_shift)] : 1'b0;
      end
      4'd8: begin
        alu_r1    = (alu_r2 >> alu_shift) | (alu_r2 << (6'd32 - {1'b0, alu_shift}));
        alu_carry = alu_r1[31];
      end
      default: alu_r1 = 32'hDEAD_BEEF;
    endcase
    alu_negative = alu_r1[31];
    alu_zero     = (alu_r1 == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Host preload, one cycle
  task automatic load_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic drive_instr(input logic [3:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [4:0] sh);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_shamt = sh;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [4:0]  sh;
    logic        exp_wbv;
    logic [31:0] exp_data;
    logic        exp_ill;
    logic [3:0]  exp_nzcv;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
    instr_rs1 = '0; instr_rs2 = '0; instr_shamt = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; dbg_addr = '0;

    //            op     rd    rs1   rs2   sh     wbv   data           ill   nzcv     reg[rd]
    vecs[0]  = '{4'd0,  3'd3, 3'd1, 3'd2, 5'd0,  1'b1, 32'd12,        1'b0, 4'b0000, 32'd12};
    vecs[1]  = '{4'd9,  3'd3, 3'd4, 3'd5, 5'd0,  1'b1, 32'd0,         1'b0, 4'b0100, 32'd12};
    vecs[2]  = '{4'd0,  3'd4, 3'd6, 3'd7, 5'd0,  1'b1, 32'h8000_0000, 1'b0, 4'b1001, 32'h8000_0000};
    vecs[3]  = '{4'd3,  3'd5, 3'd6, 3'd7, 5'd0,  1'b1, 32'h7FFF_FFFF, 1'b0, 4'b0001, 32'h7FFF_FFFF};
    vecs[4]  = '{4'd12, 3'd1, 3'd1, 3'd2, 5'd0,  1'b0, 32'd0,         1'b1, 4'b0001, 32'd5};
    vecs[5]  = '{4'd1,  3'd2, 3'd1, 3'd3, 5'd0,  1'b1, 32'hFFFF_FFF9, 1'b0, 4'b1010, 32'hFFFF_FFF9};
    vecs[6]  = '{4'd7,  3'd6, 3'd7, 3'd0, 5'd31, 1'b1, 32'h8000_0000, 1'b0, 4'b1000, 32'h8000_0000};
    vecs[7]  = '{4'd6,  3'd7, 3'd6, 3'd0, 5'd31, 1'b1, 32'd1,         1'b0, 4'b0000, 32'd1};
    vecs[8]  = '{4'd8,  3'd1, 3'd7, 3'd0, 5'd1,  1'b1, 32'h8000_0000, 1'b0, 4'b1010, 32'h8000_0000};
    vecs[9]  = '{4'd2,  3'd3, 3'd7, 3'd1, 5'd0,  1'b1, 32'h8000_0000, 1'b0, 4'b1000, 32'h8000_0000};
    vecs[10] = '{4'd4,  3'd2, 3'd4, 3'd5, 5'd0,  1'b1, 32'd0,         1'b0, 4'b0100, 32'd0};
`ifdef ALU_ISSUE_ZERO_REG_EN
    vecs[11] = '{4'd5,  3'd0, 3'd4, 3'd5, 5'd0,  1'b1, 32'hFFFF_FFFF, 1'b0, 4'b1000, 32'd0};
`else
    vecs[11] = '{4'd5,  3'd0, 3'd4, 3'd5, 5'd0,  1'b1, 32'hFFFF_FFFF, 1'b0, 4'b1000, 32'hFFFF_FFFF};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, instr_ready}, 32'd0);
    check("rst_wbv", {31'b0, wb_valid}, 32'd0);
    check("rst_nzcv", {28'b0, status_nzcv}, 32'd0);
    check("rst_optcode", {28'b0, alu_optcode}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_ready", {31'b0, instr_ready}, 32'd1);

    load_reg(3'd1, 32'd5);
    load_reg(3'd2, 32'd7);
    load_reg(3'd4, 32'd3);
    load_reg(3'd5, 32'd3);
    load_reg(3'd6, 32'h7FFF_FFFF);
    load_reg(3'd7, 32'd1);

    // Table-driven instructions
    for (int i = 0; i < 12; i++) begin
      drive_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].sh);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      check($sformatf("v%0d_busy", i), {31'b0, instr_ready}, 32'd0);
      check($sformatf("v%0d_early_wbv", i), {31'b0, wb_valid}, 32'd0);
      @(posedge clk); #1;
      dbg_addr = vecs[i].rd;
      #1;
      check($sformatf("v%0d_wbv", i), {31'b0, wb_valid}, {31'b0, vecs[i].exp_wbv});
      check($sformatf("v%0d_ill", i), {31'b0, illegal_op}, {31'b0, vecs[i].exp_ill});
      check($sformatf("v%0d_nzcv", i), {28'b0, status_nzcv}, {28'b0, vecs[i].exp_nzcv});
      check($sformatf("v%0d_reg", i), dbg_data, vecs[i].exp_reg);
      if (vecs[i].exp_wbv) begin
        check($sformatf("v%0d_data", i), wb_data, vecs[i].exp_data);
        check($sformatf("v%0d_rd", i), {29'b0, wb_rd}, {29'b0, vecs[i].rd});
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_end", i), {30'b0, wb_valid, illegal_op}, 32'd0);
    end

    // Load and issue at the same edge: operand sees the pre-load r1
    drive_instr(4'd0, 3'd2, 3'd1, 3'd1, 5'd0);
    load_en = 1'b1; load_addr = 3'd1; load_data = 32'd100;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    dbg_addr = 3'd1;
    // Load attempted during EXEC must be ignored
    load_addr = 3'd5; load_data = 32'h0000_DEAD;
    #1;
    check("same_edge_load", dbg_data, 32'd100);
    @(posedge clk); #1;
    load_en = 1'b0;
    dbg_addr = 3'd5;
    #1;
    check("same_edge_data", wb_data, 32'd0);
    check("same_edge_nzcv", {28'b0, status_nzcv}, 32'h7);
    check("exec_load_ignored", dbg_data, 32'h7FFF_FFFF);

    // Back-to-back: instr_valid held high, ready alternates
    drive_instr(4'd3, 3'd3, 3'd3, 3'd3, 5'd0);
    #1;
    check("b2b_ready0", {31'b0, instr_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ready%0d", i + 1), {31'b0, instr_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("b2b_wbv%0d", i + 1), {31'b0, wb_valid}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    instr_valid = 1'b0;
    @(posedge clk); #1;

    // Reset during EXEC: no retire, everything cleared
    drive_instr(4'd5, 3'd2, 3'd4, 3'd5, 5'd7);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, instr_ready}, 32'd0);
    check("mid_rst_alu", {alu_optcode, alu_shift, 23'b0} | alu_r2 | alu_r3, 32'd0);
    check("mid_rst_wb", {28'b0, wb_valid, illegal_op, 2'b0} | wb_data | {29'b0, wb_rd}, 32'd0);
    check("mid_rst_nzcv", {28'b0, status_nzcv}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      check($sformatf("mid_rst_r%0d", a), dbg_data, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    check("post_rst_wbv", {31'b0, wb_valid}, 32'd0);

`ifdef ALU_ISSUE_ZERO_REG_EN
    // r0 is hard-wired zero
    load_reg(3'd0, 32'd9);
    dbg_addr = 3'd0;
    #1;
    check("zr_load", dbg_data, 32'd0);
    load_reg(3'd1, 32'd4);
    drive_instr(4'd0, 3'd0, 3'd1, 3'd1, 5'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("zr_wbv", {31'b0, wb_valid}, 32'd1);
    check("zr_wbdata", wb_data, 32'd8);
    check("zr_reg", dbg_data, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
